// File: rtl/datapath_state_regs.sv
// State registers of the 16-bit CPU datapath: PC, instruction, ALU result, packed status,
// plus the combinational memory-address mux between PC and source register.
module datapath_state_regs #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             program_counter_write_enable,
  input  logic [WIDTH-1:0] next_program_counter,
  input  logic             instruction_write_enable,
  input  logic [WIDTH-1:0] memory_read_data,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             status_write_enable,
  input  logic             carry,
  input  logic             low,
  input  logic             flag,
  input  logic             zero,
  input  logic             negative,
  input  logic             memory_address_select,
  input  logic [WIDTH-1:0] source,
  output logic [WIDTH-1:0] program_counter,
  output logic [WIDTH-1:0] instruction,
  output logic [WIDTH-1:0] result,
  output logic [15:0]      status,
  output logic [WIDTH-1:0] memory_address
);

  logic [WIDTH-1:0] program_counter_r;
  logic [WIDTH-1:0] instruction_r;
  logic [WIDTH-1:0] result_r;
  logic [15:0]      status_r;
  logic [WIDTH-1:0] memory_address_s;

  // Reserved and I/P/E/T positions are tied to zero so no unused bit can carry X.
  function automatic logic [15:0] pack_status(
    input logic c, input logic l, input logic f, input logic z, input logic n
  );
    pack_status = {4'b0000, 4'b0000, n, z, f, 2'b00, l, 1'b0, c};
  endfunction

  // Program counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      program_counter_r <= {WIDTH{1'b0}};
    end else if (program_counter_write_enable) begin
      program_counter_r <= next_program_counter;
    end else begin
      program_counter_r <= program_counter_r;
    end
  end

  // Instruction register, loaded from memory read data
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction_r <= {WIDTH{1'b0}};
    end else if (instruction_write_enable) begin
      instruction_r <= memory_read_data;
    end else begin
      instruction_r <= instruction_r;
    end
  end

  // ALU result register, free-running with one cycle of latency
  always_ff @(posedge clock) begin
    if (reset) begin
      result_r <= {WIDTH{1'b0}};
    end else begin
      result_r <= alu_d;
    end
  end

  // Status register, loads the packed flag word
  always_ff @(posedge clock) begin
    if (reset) begin
      status_r <= 16'h0000;
    end else if (status_write_enable) begin
      status_r <= pack_status(carry, low, flag, zero, negative);
    end else begin
      status_r <= status_r;
    end
  end

  // Memory address mux follows the current PC register, not the next value
  always_comb begin
    memory_address_s = program_counter_r;
    case (memory_address_select)
      1'b0:    memory_address_s = program_counter_r;
      1'b1:    memory_address_s = source;
      default: memory_address_s = program_counter_r;
    endcase
  end

  assign program_counter = program_counter_r;
  assign instruction     = instruction_r;
  assign result          = result_r;
  assign status          = status_r;
  assign memory_address  = memory_address_s;

endmodule

// File: tb/tb_datapath_state_regs.sv
// Table-driven, scoreboard-checked bench for datapath_state_regs, plus hand sequences
// for the combinational address mux and result-register latency.
module tb_datapath_state_regs;

  logic        clock = 1'b0;
  logic        reset;
  logic        program_counter_write_enable;
  logic [15:0] next_program_counter;
  logic        instruction_write_enable;
  logic [15:0] memory_read_data;
  logic [15:0] alu_d;
  logic        status_write_enable;
  logic        carry, low, flag, zero, negative;
  logic        memory_address_select;
  logic [15:0] source;
  logic [15:0] program_counter, instruction, result, status, memory_address;

  int total = 0;
  int bad   = 0;

  datapath_state_regs #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .program_counter_write_enable(program_counter_write_enable),
    .next_program_counter(next_program_counter),
    .instruction_write_enable(instruction_write_enable),
    .memory_read_data(memory_read_data),
    .alu_d(alu_d),
    .status_write_enable(status_write_enable),
    .carry(carry), .low(low), .flag(flag), .zero(zero), .negative(negative),
    .memory_address_select(memory_address_select),
    .source(source),
    .program_counter(program_counter),
    .instruction(instruction),
    .result(result),
    .status(status),
    .memory_address(memory_address)
  );

  always #5 clock = ~clock;

  // flags packed as {negative, zero, flag, low, carry}
  typedef struct {
    logic        rst;
    logic        pc_we;
    logic [15:0] npc;
    logic        ir_we;
    logic [15:0] mrd;
    logic [15:0] alu;
    logic        st_we;
    logic [4:0]  flags;
    logic        sel;
    logic [15:0] src;
    logic [15:0] e_pc, e_ir, e_res, e_st, e_addr;
  } vec_t;

  typedef struct {
    logic [15:0] pc, ir, res, st, addr;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset                        = v.rst;
    program_counter_write_enable = v.pc_we;
    next_program_counter         = v.npc;
    instruction_write_enable     = v.ir_we;
    memory_read_data             = v.mrd;
    alu_d                        = v.alu;
    status_write_enable          = v.st_we;
    {negative, zero, flag, low, carry} = v.flags;
    memory_address_select        = v.sel;
    source                       = v.src;
  endtask

  initial begin
    exp_t e;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    //            rst   pc_we npc      ir_we mrd      alu      st_we flags     sel   src       e_pc     e_ir     e_res    e_st     e_addr
    vecs[0]  = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h1111, 16'h2222, 1'b1, 5'b11111, 1'b0, 16'h3333, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 16'h0005, 1'b0, 16'h1111, 16'h1234, 1'b0, 5'b00000, 1'b0, 16'h00A0, 16'h0005, 16'h0000, 16'h1234, 16'h0000, 16'h0005};
    vecs[2]  = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h1111, 16'hABCD, 1'b0, 5'b00000, 1'b1, 16'h00A0, 16'h0005, 16'h0000, 16'hABCD, 16'h0000, 16'h00A0};
    vecs[3]  = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1, 5'b11111, 1'b0, 16'h00A0, 16'h0005, 16'h0000, 16'h0000, 16'h00E5, 16'h0005};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001, 1'b0, 5'b00000, 1'b0, 16'h00A0, 16'h0005, 16'h0000, 16'h0001, 16'h00E5, 16'h0005};
    vecs[5]  = '{1'b1, 1'b1, 16'h7777, 1'b1, 16'hBEEF, 16'h9999, 1'b1, 5'b11111, 1'b0, 16'h00A0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h7777, 1'b1, 16'hBEEF, 16'h0042, 1'b0, 5'b11111, 1'b0, 16'h00A0, 16'h0000, 16'hBEEF, 16'h0042, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 16'h1230, 1'b1, 16'hCAFE, 16'h5A5A, 1'b1, 5'b10000, 1'b1, 16'hFFFF, 16'h1230, 16'hCAFE, 16'h5A5A, 16'h0080, 16'hFFFF};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 5'b01100, 1'b0, 16'hFFFF, 16'h1230, 16'hCAFE, 16'hFFFF, 16'h0060, 16'h1230};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h8000, 1'b1, 5'b00011, 1'b0, 16'hFFFF, 16'h1230, 16'hCAFE, 16'h8000, 16'h0005, 16'h1230};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 5'b01000, 1'b1, 16'h0BAD, 16'h1230, 16'hCAFE, 16'h0000, 16'h0040, 16'h0BAD};
    vecs[11] = '{1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'b00000, 1'b0, 16'h0BAD, 16'hFFFE, 16'hCAFE, 16'h0000, 16'h0040, 16'hFFFE};

    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      sb.push_back('{vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_res, vecs[i].e_st, vecs[i].e_addr});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d_pc", i),   program_counter, e.pc);
      check($sformatf("v%0d_ir", i),   instruction,     e.ir);
      check($sformatf("v%0d_res", i),  result,          e.res);
      check($sformatf("v%0d_st", i),   status,          e.st);
      check($sformatf("v%0d_addr", i), memory_address,  e.addr);
    end

    // Address mux must follow select and source with no clock edge in between.
    @(negedge clock);
    program_counter_write_enable = 1'b0;
    instruction_write_enable     = 1'b0;
    status_write_enable          = 1'b0;
    memory_address_select        = 1'b0;
    source                       = 16'h00A0;
    alu_d                        = 16'h7777;
    #1;
    check("mux_sel0", memory_address, 16'hFFFE);
    memory_address_select = 1'b1;
    #1;
    check("mux_sel1", memory_address, 16'h00A0);
    source = 16'h5555;
    #1;
    check("mux_src_change", memory_address, 16'h5555);
    check("res_before_edge", result, 16'h0000);
    @(posedge clock);
    #1;
    check("res_after_edge", result, 16'h7777);
    check("pc_hold", program_counter, 16'hFFFE);

    // Reset priority, then release and reload on the following edge.
    @(negedge clock);
    reset                    = 1'b1;
    instruction_write_enable = 1'b1;
    memory_read_data         = 16'hBEEF;
    @(posedge clock);
    #1;
    check("rst_prio_ir", instruction, 16'h0000);
    check("rst_prio_pc", program_counter, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("rst_release_ir", instruction, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
